branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
Fetch-side next-PC predictor. It is the consumer of the branch-learning signals that the execute stage registers one cycle after resolution.
- Prediction: combinationally predicts the next fetch PC from a BTB (branch target buffer), a BHT (branch history table of 2-bit counters) and a RAS (return address stack).
- Training: the structures are updated at the clock edge from the execute stage's resolved branch outcome.
- Placement: sits between the execute stage's registered branch outputs and the fetch PC mux.

Parameters:
- NUM_BTB_ENTRIES, 32, number of fully-associative BTB entries.
- NUM_BTB_ENTRIES_W, 5, log2(NUM_BTB_ENTRIES).
- NUM_BHT_ENTRIES, 512, number of 2-bit BHT counters.
- NUM_BHT_ENTRIES_W, 9, log2(NUM_BHT_ENTRIES).
- NUM_RAS_ENTRIES, 8, return address stack depth.
- NUM_RAS_ENTRIES_W, 3, log2(NUM_RAS_ENTRIES).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low. One clock; all state resets asynchronously on rstn_i low.
- branch_request_i  in  1  resolved branch/jump (taken or not-taken) this cycle.
- branch_is_taken_i  in  1  resolved taken.
- branch_is_not_taken_i  in  1  resolved not-taken.
- branch_source_i  in  32  PC of the resolved branch.
- branch_pc_i  in  32  resolved next PC: the target if taken, otherwise source+4.
- branch_is_call_i  in  1  resolved instruction is a call (JAL/JALR with rd=x1).
- branch_is_ret_i  in  1  resolved instruction is a return (JALR rs1=x1, imm=0).
- branch_is_jmp_i  in  1  resolved instruction is another unconditional jump.
- pc_f_i  in  32  current fetch PC.
- pc_accept_i  in  1  fetch consumes the prediction this cycle; used for statistics counters only.
- next_pc_f_o  out  32  predicted next fetch PC.
- next_taken_f_o  out  1  prediction is taken.

Behaviour:

Reset state:
- All BTB valid bits = 0; tags, targets and type bits = 0.
- All BHT counters = 2'b10 (weakly taken).
- RAS entries = 0; ras_idx = 0; BTB replacement pointer = 0.
- Outputs are combinational. With the BTB empty they read next_pc_f_o = pc_f_i+4, next_taken_f_o = 0.

BTB entry contents:
- valid, pc[31:0] (full tag), target[31:0], is_call, is_ret, is_jmp.
- Lookup compares pc_f_i against all valid tags. At most one entry can match, because updates hit in place.

Lookup (0-cycle, combinational):
- BHT index = pc_f_i[2 +: NUM_BHT_ENTRIES_W].
- Hit with is_ret: next_pc = ras[ras_idx], taken = 1.
- Hit with is_call or is_jmp: next_pc = entry.target, taken = 1.
- Hit on a conditional entry: if counter >= 2'b10, next_pc = target and taken = 1; otherwise pc_f_i+4 and taken = 0.
- Miss: pc_f_i+4, taken = 0.

Update (at posedge, only when branch_request_i = 1):
- BHT, indexed by branch_source_i[2 +: W]:
  - Taken: increment, saturating at 3.
  - Not-taken: decrement, saturating at 0.
  - Updated for every request, whether or not it hits the BTB.
- BTB hit on branch_source_i: if taken, overwrite target with branch_pc_i and type bits from the inputs. If not-taken, the entry is kept unchanged.
- BTB miss and taken: allocate at the replacement pointer (valid = 1, pc = source, target = branch_pc_i, type bits), then increment the pointer modulo NUM_BTB_ENTRIES (wrap 31 -> 0).
- BTB miss and not-taken: no allocation.
- RAS (non-speculative, trained at resolution):
  - Call: ras_idx <= ras_idx+1 and ras[ras_idx+1] <= branch_source_i+4.
  - Ret: ras_idx <= ras_idx-1.
  - Index arithmetic wraps modulo NUM_RAS_ENTRIES. Overflow overwrites the oldest entry; underflow wraps silently with no error flag.
  - Call and ret are mutually exclusive by decode. If both are asserted, call wins.

Boundary conditions:
- Same-cycle lookup and update of the same PC: the lookup sees pre-edge contents; the new state is visible the next cycle.
- branch_request_i = 0: no state change, regardless of the other branch inputs.
- Both taken and not-taken asserted is illegal; taken wins.
- pc_accept_i does not alter predictor state.
- rstn_i low mid-operation: all state returns to reset values immediately (asynchronous). The first post-reset prediction is a miss.

Test Plan:
1. Reset, pc_f_i=0x8000_0000 -> next_pc_f_o=0x8000_0004, next_taken_f_o=0.
2. Taken update, source 0x100, branch_pc 0x200 -> next cycle pc_f_i=0x100 gives next_pc_f_o=0x200, taken=1; BHT[0x40]=3.
3. Continue from 2: three not-taken updates at 0x100 -> counter 3->2->1->0; predicts 0x104, taken=0; BTB entry still valid. One taken update -> counter 1, still 0x104; second taken update -> counter 2, predicts 0x200.
4. Call update at source 0x300 (is_call, target 0x400), then ret update at source 0x480 (target 0x304) -> after the ret the stack is popped. Required checks:
   - After the call only, lookup 0x480 is a miss.
   - Re-issuing the call, then lookup 0x480, predicts 0x304, taken=1.
5. RAS overflow: 9 calls at sources 0x1000+0x10*k (k=0..8), with a ret entry already in the BTB -> predicted returns pop 0x1084, 0x1074, ... 0x1014. The 9th pop yields 0x1084 again, because the slot was overwritten via wrap.
6. BTB replacement: 33 distinct taken sources 0x0..0x80 step 4 -> source 0x0 is evicted (miss, predicts 0x4), source 0x4 still hits. Assert rstn_i low mid-sequence -> all lookups miss on the next cycle.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side next-PC predictor: fully-associative BTB, 2-bit BHT and a return address stack,
// trained from the execute stage's registered branch resolution.
module branch_predictor #(
    parameter int NUM_BTB_ENTRIES   = 32,
    parameter int NUM_BTB_ENTRIES_W = 5,
    parameter int NUM_BHT_ENTRIES   = 512,
    parameter int NUM_BHT_ENTRIES_W = 9,
    parameter int NUM_RAS_ENTRIES   = 8,
    parameter int NUM_RAS_ENTRIES_W = 3
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        branch_request_i,
    input  logic        branch_is_taken_i,
    input  logic        branch_is_not_taken_i,
    input  logic [31:0] branch_source_i,
    input  logic [31:0] branch_pc_i,
    input  logic        branch_is_call_i,
    input  logic        branch_is_ret_i,
    input  logic        branch_is_jmp_i,
    input  logic [31:0] pc_f_i,
    input  logic        pc_accept_i,
    output logic [31:0] next_pc_f_o,
    output logic        next_taken_f_o
);

    logic                         btb_valid_q  [NUM_BTB_ENTRIES];
    logic [31:0]                  btb_pc_q     [NUM_BTB_ENTRIES];
    logic [31:0]                  btb_target_q [NUM_BTB_ENTRIES];
    logic                         btb_call_q   [NUM_BTB_ENTRIES];
    logic                         btb_ret_q    [NUM_BTB_ENTRIES];
    logic                         btb_jmp_q    [NUM_BTB_ENTRIES];
    logic                         btb_valid_d  [NUM_BTB_ENTRIES];
    logic [31:0]                  btb_pc_d     [NUM_BTB_ENTRIES];
    logic [31:0]                  btb_target_d [NUM_BTB_ENTRIES];
    logic                         btb_call_d   [NUM_BTB_ENTRIES];
    logic                         btb_ret_d    [NUM_BTB_ENTRIES];
    logic                         btb_jmp_d    [NUM_BTB_ENTRIES];
    logic [1:0]                   bht_q        [NUM_BHT_ENTRIES];
    logic [1:0]                   bht_d        [NUM_BHT_ENTRIES];
    logic [31:0]                  ras_q        [NUM_RAS_ENTRIES];
    logic [31:0]                  ras_d        [NUM_RAS_ENTRIES];
    logic [NUM_RAS_ENTRIES_W-1:0] ras_idx_q, ras_idx_d;
    logic [NUM_BTB_ENTRIES_W-1:0] btb_ptr_q, btb_ptr_d;
    logic [31:0]                  accept_cnt_q, accept_cnt_d;
    logic [31:0]                  accept_taken_cnt_q, accept_taken_cnt_d;

    logic                         lk_hit, lk_call, lk_ret, lk_jmp;
    logic [31:0]                  lk_target;
    logic [1:0]                   lk_ctr;
    logic                         up_hit;
    logic [NUM_BTB_ENTRIES_W-1:0] up_idx;
    logic                         up_taken, up_not_taken;
    logic [NUM_BHT_ENTRIES_W-1:0] up_bht_idx;
    logic [NUM_RAS_ENTRIES_W-1:0] ras_push_idx;

    // Lookup: tags are unique, so OR-merging the matching entry's fields is a clean mux.
    always_comb begin
        lk_hit    = 1'b0;
        lk_call   = 1'b0;
        lk_ret    = 1'b0;
        lk_jmp    = 1'b0;
        lk_target = '0;
        for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
            if (btb_valid_q[i] && (btb_pc_q[i] == pc_f_i)) begin
                lk_hit    = 1'b1;
                lk_call   = lk_call | btb_call_q[i];
                lk_ret    = lk_ret  | btb_ret_q[i];
                lk_jmp    = lk_jmp  | btb_jmp_q[i];
                lk_target = lk_target | btb_target_q[i];
            end
        end
        lk_ctr = bht_q[pc_f_i[2 +: NUM_BHT_ENTRIES_W]];

        next_pc_f_o    = pc_f_i + 32'd4;
        next_taken_f_o = 1'b0;
        if (lk_hit) begin
            if (lk_ret) begin
                next_pc_f_o    = ras_q[ras_idx_q];
                next_taken_f_o = 1'b1;
            end else if (lk_call || lk_jmp || lk_ctr[1]) begin
                next_pc_f_o    = lk_target;
                next_taken_f_o = 1'b1;
            end
        end
    end

    always_comb begin
        up_hit = 1'b0;
        up_idx = '0;
        for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
            if (btb_valid_q[i] && (btb_pc_q[i] == branch_source_i)) begin
                up_hit = 1'b1;
                up_idx = NUM_BTB_ENTRIES_W'(i);
            end
        end
    end

    // Taken wins when both outcome flags are raised.
    assign up_taken     = branch_is_taken_i;
    assign up_not_taken = branch_is_not_taken_i & ~branch_is_taken_i;
    assign up_bht_idx   = branch_source_i[2 +: NUM_BHT_ENTRIES_W];
    assign ras_push_idx = ras_idx_q + NUM_RAS_ENTRIES_W'(1);

    always_comb begin
        btb_valid_d        = btb_valid_q;
        btb_pc_d           = btb_pc_q;
        btb_target_d       = btb_target_q;
        btb_call_d         = btb_call_q;
        btb_ret_d          = btb_ret_q;
        btb_jmp_d          = btb_jmp_q;
        bht_d              = bht_q;
        ras_d              = ras_q;
        ras_idx_d          = ras_idx_q;
        btb_ptr_d          = btb_ptr_q;
        accept_cnt_d       = accept_cnt_q;
        accept_taken_cnt_d = accept_taken_cnt_q;

        if (pc_accept_i) begin
            accept_cnt_d = accept_cnt_q + 32'd1;
            if (next_taken_f_o) begin
                accept_taken_cnt_d = accept_taken_cnt_q + 32'd1;
            end
        end

        if (branch_request_i) begin
            if (up_taken && (bht_q[up_bht_idx] != 2'b11)) begin
                bht_d[up_bht_idx] = bht_q[up_bht_idx] + 2'd1;
            end else if (up_not_taken && (bht_q[up_bht_idx] != 2'b00)) begin
                bht_d[up_bht_idx] = bht_q[up_bht_idx] - 2'd1;
            end

            if (up_taken) begin
                if (up_hit) begin
                    btb_target_d[up_idx] = branch_pc_i;
                    btb_call_d[up_idx]   = branch_is_call_i;
                    btb_ret_d[up_idx]    = branch_is_ret_i;
                    btb_jmp_d[up_idx]    = branch_is_jmp_i;
                end else begin
                    btb_valid_d[btb_ptr_q]  = 1'b1;
                    btb_pc_d[btb_ptr_q]     = branch_source_i;
                    btb_target_d[btb_ptr_q] = branch_pc_i;
                    btb_call_d[btb_ptr_q]   = branch_is_call_i;
                    btb_ret_d[btb_ptr_q]    = branch_is_ret_i;
                    btb_jmp_d[btb_ptr_q]    = branch_is_jmp_i;
                    btb_ptr_d               = btb_ptr_q + NUM_BTB_ENTRIES_W'(1);
                end
            end

            // Stack wraps silently; a push past depth overwrites the oldest return.
            if (branch_is_call_i) begin
                ras_idx_d           = ras_push_idx;
                ras_d[ras_push_idx] = branch_source_i + 32'd4;
            end else if (branch_is_ret_i) begin
                ras_idx_d = ras_idx_q - NUM_RAS_ENTRIES_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_pc_q[i]     <= '0;
                btb_target_q[i] <= '0;
                btb_call_q[i]   <= 1'b0;
                btb_ret_q[i]    <= 1'b0;
                btb_jmp_q[i]    <= 1'b0;
            end
            for (int i = 0; i < NUM_BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b10;
            end
            for (int i = 0; i < NUM_RAS_ENTRIES; i++) begin
                ras_q[i] <= '0;
            end
            ras_idx_q          <= '0;
            btb_ptr_q          <= '0;
            accept_cnt_q       <= '0;
            accept_taken_cnt_q <= '0;
        end else begin
            btb_valid_q        <= btb_valid_d;
            btb_pc_q           <= btb_pc_d;
            btb_target_q       <= btb_target_d;
            btb_call_q         <= btb_call_d;
            btb_ret_q          <= btb_ret_d;
            btb_jmp_q          <= btb_jmp_d;
            bht_q              <= bht_d;
            ras_q              <= ras_d;
            ras_idx_q          <= ras_idx_d;
            btb_ptr_q          <= btb_ptr_d;
            accept_cnt_q       <= accept_cnt_d;
            accept_taken_cnt_q <= accept_taken_cnt_d;
        end
    end

endmodule
